// File: rtl/csi_sequence_parser.sv
// Byte-stream ANSI/VT100 parser: emits CHAR, ESC and CSI command records with numeric parameters.
// Latency 1 cycle (registered record); no backpressure, accepts one byte per cycle.
module csi_sequence_parser #(
    parameter int MAX_PARAMS = 4,
    parameter int PARAM_W    = 8,
    parameter int CNT_W      = $clog2(MAX_PARAMS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data,
    input  logic                          dataReady,
    output logic                          commandReady,
    output logic [1:0]                    commandClass,
    output logic [7:0]                    finalByte,
    output logic                          isPrivate,
    output logic [CNT_W-1:0]              paramCount,
    output logic [MAX_PARAMS*PARAM_W-1:0] params,
    output logic                          paramOverflow
);
    localparam logic [2:0] S_GROUND    = 3'd0;
    localparam logic [2:0] S_ESCAPE    = 3'd1;
    localparam logic [2:0] S_CSI_ENTRY = 3'd2;
    localparam logic [2:0] S_CSI_PARAM = 3'd3;
    localparam logic [2:0] S_CSI_IGN   = 3'd4;

    localparam int                 ACC_W   = PARAM_W + 4;
    localparam logic [ACC_W-1:0]   ACC_MAX = {4'b0000, {PARAM_W{1'b1}}};
    localparam logic [CNT_W-1:0]   IDX_MAX = CNT_W'(MAX_PARAMS);
    localparam int                 SLOT_W  = MAX_PARAMS * PARAM_W;

    logic [2:0]        state, n_state;
    logic [ACC_W-1:0]  acc, n_acc;
    logic [CNT_W-1:0]  idx, n_idx;
    logic [SLOT_W-1:0] slots, n_slots;
    logic              priv, n_priv;
    logic              ovf, n_ovf;
    logic              seen, n_seen;

    logic              is_digit, is_sep, is_final, is_abort, is_esc, is_c0;
    logic [ACC_W-1:0]  acc_calc, acc_sat;
    logic [SLOT_W-1:0] closed_slots;
    logic              close_ovf;
    logic [CNT_W-1:0]  idx_inc;

    logic              em;
    logic [1:0]        em_class;
    logic              em_priv, em_ovf;
    logic [CNT_W-1:0]  em_count;
    logic [SLOT_W-1:0] em_params;

    assign is_digit = (data >= 8'h30) && (data <= 8'h39);
    assign is_sep   = (data == 8'h3B);
    assign is_final = (data >= 8'h40) && (data <= 8'h7E);
    assign is_abort = (data == 8'h18) || (data == 8'h1A);
    assign is_esc   = (data == 8'h1B);
    assign is_c0    = (data < 8'h20) && !is_esc && !is_abort;

    // acc*10 + digit; acc never exceeds ACC_MAX so this cannot wrap ACC_W bits
    assign acc_calc = {acc[ACC_W-4:0], 3'b000} + {acc[ACC_W-2:0], 1'b0}
                    + {{(ACC_W-4){1'b0}}, data[3:0]};
    assign acc_sat  = (acc_calc > ACC_MAX) ? ACC_MAX : acc_calc;

    // Closing the open field: idx saturates at MAX_PARAMS, which doubles as "no slot left"
    always_comb begin
        closed_slots = slots;
        for (int i = 0; i < MAX_PARAMS; i++) begin
            if (idx == CNT_W'(i))
                closed_slots[i*PARAM_W +: PARAM_W] = acc[PARAM_W-1:0];
        end
    end
    assign close_ovf = ovf | (idx == IDX_MAX);
    assign idx_inc   = (idx == IDX_MAX) ? idx : idx + CNT_W'(1);

    always_comb begin
        n_state   = state;
        n_acc     = acc;
        n_idx     = idx;
        n_slots   = slots;
        n_priv    = priv;
        n_ovf     = ovf;
        n_seen    = seen;
        em        = 1'b0;
        em_class  = 2'd0;
        em_priv   = 1'b0;
        em_ovf    = 1'b0;
        em_count  = '0;
        em_params = '0;
        if (dataReady) begin
            case (state)
                S_GROUND: begin
                    if (is_esc) n_state = S_ESCAPE;
                    else        em = 1'b1;
                end
                S_ESCAPE: begin
                    if (data == 8'h5B) begin
                        n_state = S_CSI_ENTRY;
                        n_acc   = '0;
                        n_idx   = '0;
                        n_slots = '0;
                        n_priv  = 1'b0;
                        n_ovf   = 1'b0;
                        n_seen  = 1'b0;
                    end else if (is_esc) begin
                        n_state = S_ESCAPE;
                    end else if (data >= 8'h30 && data <= 8'h7E) begin
                        em       = 1'b1;
                        em_class = 2'd1;
                        n_state  = S_GROUND;
                    end else begin
                        n_state = S_GROUND;
                    end
                end
                S_CSI_ENTRY, S_CSI_PARAM: begin
                    if (is_esc) begin
                        n_state = S_ESCAPE;
                    end else if (is_abort) begin
                        n_state = S_GROUND;
                    end else if (is_c0) begin
                        n_state = state;
                    end else if (is_digit) begin
                        n_acc   = acc_sat;
                        n_seen  = 1'b1;
                        n_state = S_CSI_PARAM;
                    end else if (is_sep) begin
                        n_slots = closed_slots;
                        n_ovf   = close_ovf;
                        n_idx   = idx_inc;
                        n_acc   = '0;
                        n_seen  = 1'b1;
                        n_state = S_CSI_PARAM;
                    end else if (is_final) begin
                        // seen=0 means no digit or separator yet: zero fields
                        em        = 1'b1;
                        em_class  = 2'd2;
                        em_priv   = priv;
                        em_params = seen ? closed_slots : slots;
                        em_ovf    = seen ? close_ovf : ovf;
                        em_count  = seen ? idx_inc : '0;
                        n_state   = S_GROUND;
                    end else if (data == 8'h3F && state == S_CSI_ENTRY) begin
                        n_priv  = 1'b1;
                        n_state = S_CSI_PARAM;
                    end else begin
                        n_state = S_CSI_IGN;
                    end
                end
                S_CSI_IGN: begin
                    if (is_final || is_abort) n_state = S_GROUND;
                    else if (is_esc)          n_state = S_ESCAPE;
                end
                default: n_state = S_GROUND;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_GROUND;
            acc           <= '0;
            idx           <= '0;
            slots         <= '0;
            priv          <= 1'b0;
            ovf           <= 1'b0;
            seen          <= 1'b0;
            commandReady  <= 1'b0;
            commandClass  <= 2'd0;
            finalByte     <= 8'h00;
            isPrivate     <= 1'b0;
            paramCount    <= '0;
            params        <= '0;
            paramOverflow <= 1'b0;
        end else begin
            state        <= n_state;
            acc          <= n_acc;
            idx          <= n_idx;
            slots        <= n_slots;
            priv         <= n_priv;
            ovf          <= n_ovf;
            seen         <= n_seen;
            commandReady <= em;
            if (em) begin
                commandClass  <= em_class;
                finalByte     <= data;
                isPrivate     <= em_priv;
                paramCount    <= em_count;
                params        <= em_params;
                paramOverflow <= em_ovf;
            end
        end
    end
endmodule

// File: tb/tb_csi_sequence_parser.sv
// Scoreboard bench for csi_sequence_parser: directed byte streams, expected records queued at issue.
module tb_csi_sequence_parser;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        dataReady;
    logic        commandReady;
    logic [1:0]  commandClass;
    logic [7:0]  finalByte;
    logic        isPrivate;
    logic [2:0]  paramCount;
    logic [31:0] params;
    logic        paramOverflow;

    csi_sequence_parser #(.MAX_PARAMS(4), .PARAM_W(8)) dut (
        .clk(clk), .rst(rst), .data(data), .dataReady(dataReady),
        .commandReady(commandReady), .commandClass(commandClass), .finalByte(finalByte),
        .isPrivate(isPrivate), .paramCount(paramCount), .params(params),
        .paramOverflow(paramOverflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cls;
        logic [7:0]  fb;
        logic        priv;
        logic [2:0]  cnt;
        logic [31:0] prm;
        logic        ovf;
        int          cyc;
    } rec_t;

    rec_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the head of the queue, including arrival cycle
    always @(negedge clk) begin
        if (commandReady === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_emit: got class=%0d byte=%02h at cycle %0d, expected none",
                         commandClass, finalByte, cyc);
            end else begin
                rec_t e;
                e = q.pop_front();
                if (commandClass !== e.cls || finalByte !== e.fb || isPrivate !== e.priv ||
                    paramCount !== e.cnt || params !== e.prm || paramOverflow !== e.ovf ||
                    cyc != e.cyc)
                    $display("FAIL record_%02h: got cls=%0d fb=%02h priv=%0d cnt=%0d prm=%08h ovf=%0d cyc=%0d, expected cls=%0d fb=%02h priv=%0d cnt=%0d prm=%08h ovf=%0d cyc=%0d",
                             e.fb, commandClass, finalByte, isPrivate, paramCount, params,
                             paramOverflow, cyc, e.cls, e.fb, e.priv, e.cnt, e.prm, e.ovf, e.cyc);
                else
                    passes++;
            end
        end
    end

    // Called at a negedge just before the emitting byte is driven
    task automatic expect_rec(input logic [1:0] cls, input logic [7:0] fb, input logic priv,
                              input logic [2:0] cnt, input logic [31:0] prm, input logic ovf);
        rec_t e;
        e.cls = cls; e.fb = fb; e.priv = priv; e.cnt = cnt; e.prm = prm; e.ovf = ovf;
        e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        data      = b;
        dataReady = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        dataReady = 1'b0;
        data      = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_char_exp(input logic [7:0] b);
        expect_rec(2'd0, b, 1'b0, 3'd0, 32'h0, 1'b0);
        send(b);
    endtask

    initial begin
        rst       = 1'b0;
        dataReady = 1'b1;
        data      = 8'h41;
        @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (commandReady !== 1'b0 || commandClass !== 2'd0 || finalByte !== 8'h00 ||
            isPrivate !== 1'b0 || paramCount !== 3'd0 || params !== 32'h0 || paramOverflow !== 1'b0)
            $display("FAIL reset_outputs: got rdy=%0d cls=%0d fb=%02h priv=%0d cnt=%0d prm=%08h ovf=%0d, expected all 0",
                     commandReady, commandClass, finalByte, isPrivate, paramCount, params, paramOverflow);
        else
            passes++;
        dataReady = 1'b0;
        rst       = 1'b1;
        idle(2);

        // Plain text at full rate
        send_char_exp(8'h48);
        send_char_exp(8'h69);
        idle(2);

        // ESC [ 1 2 ; 4 0 H
        send(8'h1B); send_str("[12;40");
        expect_rec(2'd2, 8'h48, 1'b0, 3'd2, 32'h0000_280C, 1'b0);
        send("H");
        idle(2);

        // ESC [ m
        send(8'h1B); send("[");
        expect_rec(2'd2, 8'h6D, 1'b0, 3'd0, 32'h0, 1'b0);
        send("m");
        idle(1);

        // ESC [ ; 5 m
        send(8'h1B); send_str("[;5");
        expect_rec(2'd2, 8'h6D, 1'b0, 3'd2, 32'h0000_0500, 1'b0);
        send("m");
        idle(1);

        // ESC [ ? 2 5 l
        send(8'h1B); send_str("[?25");
        expect_rec(2'd2, 8'h6C, 1'b1, 3'd1, 32'h0000_0019, 1'b0);
        send("l");
        idle(1);

        // ESC [ 3 0 0 A saturates
        send(8'h1B); send_str("[300");
        expect_rec(2'd2, 8'h41, 1'b0, 3'd1, 32'h0000_00FF, 1'b0);
        send("A");
        idle(1);

        // Six fields into four slots
        send(8'h1B); send_str("[1;2;3;4;5;6");
        expect_rec(2'd2, 8'h6D, 1'b0, 3'd4, 32'h0403_0201, 1'b1);
        send("m");
        idle(1);

        // CAN abort then 'x'
        send(8'h1B); send_str("[12"); send(8'h18);
        send_char_exp(8'h78);
        idle(1);

        // ESC inside CSI restarts escape
        send(8'h1B); send_str("[1"); send(8'h1B);
        expect_rec(2'd1, 8'h44, 1'b0, 3'd0, 32'h0, 1'b0);
        send("D");
        idle(1);

        // Intermediate byte sends the sequence to ignore
        send(8'h1B); send_str("[1$q");
        send_char_exp(8'h78);
        idle(1);

        // CSI final immediately followed by a character
        send(8'h1B); send_str("[5");
        expect_rec(2'd2, 8'h6D, 1'b0, 3'd1, 32'h0000_0005, 1'b0);
        send("m");
        send_char_exp(8'h7A);
        idle(1);

        // Reset mid-sequence: remaining bytes are plain characters
        send(8'h1B); send_str("[12");
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        send_char_exp(8'h33);
        send_char_exp(8'h6D);
        idle(4);

        checks++;
        if (q.size() != 0)
            $display("FAIL missing_emits: got %0d records outstanding, expected 0", q.size());
        else
            passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
